cache_data_array: RTL and testbench
===================================

# cache_data_array

Set-associative tag/data array for the L1 data cache, one instance per bank. It extends the random-replacement cache SRAM block with:
- a registered two-stage lookup;
- per-way dirty bits;
- byte-masked stores;
- an invalidate operation;
- tree-PLRU victim selection;
- write-to-lookup forwarding.

It sits between the cache controller pipeline and the refill/writeback unit.

## Interface
- SETS, 64, sets per bank (power of 2)
- WAYS, 4, ways per set (power of 2, ≥2)
- ADDR_WIDTH, 64, address width
- LINE_BYTES, 64, cacheline size in bytes
- BANKS, 2, bank count; $clog2(BANKS) address bits sit above offset and are skipped
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_lookup_req  in  1  lookup request
- o_lookup_gnt  out  1  lookup accepted this cycle
- i_lookup_addr  in  ADDR_WIDTH  lookup address
- i_squash  in  1  kill lookup currently in s1
- o_resp_vld  out  1  lookup result valid
- o_resp_hit  out  1  tag hit
- o_resp_way_vec  out  WAYS  one-hot: hit way, else victim way
- o_resp_data  out  8*LINE_BYTES  hit line, else victim line
- o_resp_victim_dirty  out  1  victim valid and dirty (0 on hit)
- i_write_req  in  1  write request (always accepted)
- i_write_op  in  2  0 fill, 1 store, 2 invalidate, 3 reserved (no-op)
- i_write_addr  in  ADDR_WIDTH  index, and tag for fill
- i_write_way_vec  in  WAYS  one-hot target way
- i_write_data  in  8*LINE_BYTES  line data
- i_write_byte_mask  in  LINE_BYTES  store byte enables
- i_write_dirty  in  1  dirty value written on fill

## Operation
- Address fields:
  - offset = [$clog2(LINE_BYTES)-1:0];
  - index = next $clog2(SETS) bits above offset+bank bits;
  - tag = remaining upper bits.
- Per way per set: vld, dirty, tag, data. Reset clears all vld, dirty and PLRU bits. Data and tag are not reset.
- Arbitration: o_lookup_gnt = i_lookup_req & !i_write_req. Write always wins.
- Fill: tag ← addr tag, vld=1, dirty=i_write_dirty, full data written. Updates PLRU as an access to that way.
- Store: data bytes with mask=1 written; dirty=1; tag and vld unchanged. No PLRU update.
- Invalidate: vld=0, dirty=0. Data kept. No PLRU update.
- A write_way_vec that is not one-hot is an assertion failure.
- Lookup s1:
  - read all ways of the index and compare tags with vld;
  - at most one hit (asserted).
- Victim selection:
  - lowest-indexed invalid way, if any;
  - else the PLRU victim.
- Tree-PLRU: WAYS-1 bits per set.
  - Node bit 0 means the victim is in the lower half.
  - Access to a way sets every node on its path to point away from it.
- PLRU is updated on a non-squashed s1 hit and on fill. On a simultaneous hit and fill to the same set, apply the hit update first, then the fill update.
- Forwarding: a write in the cycle a lookup occupies s1, same index, must be reflected in that lookup's response (hit, data, dirty, victim).
- Squash: i_squash while a lookup is in s1 cancels it, with no o_resp_vld and no PLRU update. i_squash with s1 empty is ignored.

## Timing
- Lookup granted in cycle T:
  - s1 at T+1;
  - o_resp_* registered, valid for exactly one cycle at T+2.
- Throughput is one lookup per cycle; back-to-back lookups are pipelined.
- Write issued at cycle T is visible to any lookup granted at T+1 or later. A lookup already in s1 at T is forwarded per Operation.
- A lookup granted at T-1 with a write at T: the s2 response reflects the post-write state.
- All outputs reset to 0 while rst=0. Reset mid-lookup drops every in-flight request; no response is produced after release.
- o_lookup_gnt is combinational from the inputs; all o_resp_* are registered.

## Test plan
- After reset, lookup 0x1000 -> T+2: resp_vld=1, hit=0, way_vec=0001, victim_dirty=0.
- Fill way 2 at index of 0x1000 with pattern P, dirty=0; lookup 0x1000 -> hit=1, way_vec=0100, data=P.
- Store mask=0x1, data byte0=0xAA to way 2; lookup -> hit=1, byte0=0xAA, other bytes = P. Invalidate way 2; lookup -> hit=0.
- Write and lookup in the same cycle -> gnt=0. Lookup granted at T with a store at T+1 to the same index -> response at T+2 shows the stored byte.
- Fill ways 0,1,2,3 of one set, hit way 0, hit way 2; miss lookup to that set -> way_vec=0010, victim_dirty per way 1's fill.
- Squash in s1 -> no resp_vld, next miss victim unchanged. Drive rst low during s1 -> all outputs 0, no response after release.

Source files
------------

// File: rtl/cache_data_array.sv
// -----------------------------------------------------------------------------
// cache_data_array
//   Set-associative tag/data array for one bank of the L1 data cache.
//   Lookups take two registered stages:
//     - s1 reads every way of the set, compares tags and picks a hit way or a
//       victim. The victim is the lowest invalid way, otherwise the tree-PLRU
//       way.
//     - s2 holds the registered response.
//   Writes are always accepted and block a lookup grant in the same cycle.
//   Supported writes: fill, byte-masked store and invalidate.
//   A write in the same cycle as an s1 lookup to the same set is forwarded
//   into that lookup's response.
//
// Ports
//   clk, rst                    clock, async active-low reset
//   i_lookup_req/o_lookup_gnt   lookup handshake (gnt = req & !write_req)
//   i_lookup_addr               lookup address
//   i_squash                    cancel the lookup currently in s1
//   o_resp_*                    registered lookup response (vld pulses 1 cycle)
//   i_write_*                   fill/store/invalidate request and payload
// -----------------------------------------------------------------------------
module cache_data_array #(
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BYTES = 64,
  parameter int BANKS      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_lookup_req,
  output logic                    o_lookup_gnt,
  input  logic [ADDR_WIDTH-1:0]   i_lookup_addr,
  input  logic                    i_squash,
  output logic                    o_resp_vld,
  output logic                    o_resp_hit,
  output logic [WAYS-1:0]         o_resp_way_vec,
  output logic [8*LINE_BYTES-1:0] o_resp_data,
  output logic                    o_resp_victim_dirty,
  input  logic                    i_write_req,
  input  logic [1:0]              i_write_op,
  input  logic [ADDR_WIDTH-1:0]   i_write_addr,
  input  logic [WAYS-1:0]         i_write_way_vec,
  input  logic [8*LINE_BYTES-1:0] i_write_data,
  input  logic [LINE_BYTES-1:0]   i_write_byte_mask,
  input  logic                    i_write_dirty
);

  localparam int LINE_W  = 8 * LINE_BYTES;
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int BANK_W  = $clog2(BANKS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int IDX_LSB = OFF_W + BANK_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  // Tree nodes are heap-ordered: node n has children 2n+1 (lower) and 2n+2
  // (upper). A node bit of 0 steers the victim toward the lower half.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] t;
    int node;
    t    = tree;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      t[node] = ~way[WAY_W-1-l];
      node    = way[WAY_W-1-l] ? 2*node + 2 : 2*node + 1;
    end
    return t;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] tree);
    logic [WAY_W-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      way[WAY_W-1-l] = tree[node];
      node           = tree[node] ? 2*node + 2 : 2*node + 1;
    end
    return way;
  endfunction

  function automatic logic [WAY_W-1:0] oh_to_idx(input logic [WAYS-1:0] vec);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vec[w]) idx = idx | WAY_W'(w);
    end
    return idx;
  endfunction

  function automatic logic [LINE_W-1:0] byte_merge(input logic [LINE_W-1:0]     old_line,
                                                   input logic [LINE_W-1:0]     new_line,
                                                   input logic [LINE_BYTES-1:0] mask);
    logic [LINE_W-1:0] m;
    m = old_line;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (mask[b]) m[8*b +: 8] = new_line[8*b +: 8];
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode and write decode
  // ---------------------------------------------------------------------------
  logic             w_gnt;
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic [WAY_W-1:0] w_wr_way;
  logic             w_wr_fill;
  logic             w_wr_store;
  logic             w_wr_inv;
  logic             w_unused_addr_bits;

  assign w_gnt        = rst & i_lookup_req & ~i_write_req;
  assign o_lookup_gnt = w_gnt;

  assign w_lk_idx = i_lookup_addr[IDX_LSB +: IDX_W];
  assign w_lk_tag = i_lookup_addr[TAG_LSB +: TAG_W];
  assign w_wr_idx = i_write_addr[IDX_LSB +: IDX_W];
  assign w_wr_tag = i_write_addr[TAG_LSB +: TAG_W];
  assign w_wr_way = oh_to_idx(i_write_way_vec);

  // Line offset and bank-select bits play no part in the array.
  assign w_unused_addr_bits = ^{i_lookup_addr[IDX_LSB-1:0], i_write_addr[IDX_LSB-1:0]};

  assign w_wr_fill  = i_write_req & (i_write_op == OP_FILL);
  assign w_wr_store = i_write_req & (i_write_op == OP_STORE);
  assign w_wr_inv   = i_write_req & (i_write_op == OP_INV);

  // ---------------------------------------------------------------------------
  // s1 pipeline register
  // ---------------------------------------------------------------------------
  logic             r_s1_vld;
  logic [IDX_W-1:0] r_s1_idx;
  logic [TAG_W-1:0] r_s1_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld <= 1'b0;
      r_s1_idx <= '0;
      r_s1_tag <= '0;
    end else begin
      r_s1_vld <= w_gnt;
      if (w_gnt) begin
        r_s1_idx <= w_lk_idx;
        r_s1_tag <= w_lk_tag;
      end
    end
  end

  // A write to the set currently in s1 is folded into that lookup.
  logic w_fwd;
  assign w_fwd = i_write_req & (w_wr_idx == r_s1_idx);

  // ---------------------------------------------------------------------------
  // Tag / data storage (not reset) and per-way forwarding
  // ---------------------------------------------------------------------------
  logic [WAYS-1:0][LINE_W-1:0] w_wr_line;
  logic [WAYS-1:0][LINE_W-1:0] w_rd_data;
  logic [WAYS-1:0][TAG_W-1:0]  w_rd_tag;
  logic [WAYS-1:0][LINE_W-1:0] w_eff_data;
  logic [WAYS-1:0][TAG_W-1:0]  w_eff_tag;
  logic [WAYS-1:0]             w_eff_vld;
  logic [WAYS-1:0]             w_eff_dirty;
  logic [WAYS-1:0]             w_hit_vec;

  for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
    logic [LINE_W-1:0] r_data [SETS];
    logic [TAG_W-1:0]  r_tag  [SETS];

    // New line contents for this way. When forwarding, the write index
    // equals the s1 index, so the same value also serves as the forwarded line.
    assign w_wr_line[gw] = w_wr_fill ? i_write_data
                                     : byte_merge(r_data[w_wr_idx], i_write_data,
                                                  i_write_byte_mask);

    always_ff @(posedge clk) begin
      if (i_write_way_vec[gw] && (w_wr_fill || w_wr_store)) begin
        r_data[w_wr_idx] <= w_wr_line[gw];
      end
      if (i_write_way_vec[gw] && w_wr_fill) begin
        r_tag[w_wr_idx] <= w_wr_tag;
      end
    end

    assign w_rd_data[gw] = r_data[r_s1_idx];
    assign w_rd_tag[gw]  = r_tag[r_s1_idx];

    assign w_eff_tag[gw]  = (w_fwd && w_wr_fill && i_write_way_vec[gw]) ? w_wr_tag
                                                                        : w_rd_tag[gw];
    assign w_eff_data[gw] = (w_fwd && (w_wr_fill || w_wr_store) && i_write_way_vec[gw])
                            ? w_wr_line[gw] : w_rd_data[gw];
    assign w_hit_vec[gw]  = w_eff_vld[gw] && (w_eff_tag[gw] == r_s1_tag);
  end

  // ---------------------------------------------------------------------------
  // Valid / dirty / PLRU state (reset)
  // ---------------------------------------------------------------------------
  logic [SETS-1:0][WAYS-1:0] r_vld;
  logic [SETS-1:0][WAYS-1:0] r_dirty;
  logic [SETS-1:0][WAYS-2:0] r_plru;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld   <= '0;
      r_dirty <= '0;
    end else if (w_wr_fill) begin
      r_vld[w_wr_idx]   <= r_vld[w_wr_idx] | i_write_way_vec;
      r_dirty[w_wr_idx] <= (r_dirty[w_wr_idx] & ~i_write_way_vec)
                         | (i_write_way_vec & {WAYS{i_write_dirty}});
    end else if (w_wr_store) begin
      r_dirty[w_wr_idx] <= r_dirty[w_wr_idx] | i_write_way_vec;
    end else if (w_wr_inv) begin
      r_vld[w_wr_idx]   <= r_vld[w_wr_idx]   & ~i_write_way_vec;
      r_dirty[w_wr_idx] <= r_dirty[w_wr_idx] & ~i_write_way_vec;
    end
  end

  // Forwarded valid/dirty/PLRU view of the s1 set.
  logic [WAYS-2:0] w_eff_plru;

  always_comb begin
    w_eff_vld   = r_vld[r_s1_idx];
    w_eff_dirty = r_dirty[r_s1_idx];
    w_eff_plru  = r_plru[r_s1_idx];
    if (w_fwd) begin
      if (w_wr_fill) begin
        w_eff_vld   = w_eff_vld | i_write_way_vec;
        w_eff_dirty = (w_eff_dirty & ~i_write_way_vec)
                    | (i_write_way_vec & {WAYS{i_write_dirty}});
        w_eff_plru  = plru_touch(w_eff_plru, w_wr_way);
      end else if (w_wr_store) begin
        w_eff_dirty = w_eff_dirty | i_write_way_vec;
      end else if (w_wr_inv) begin
        w_eff_vld   = w_eff_vld   & ~i_write_way_vec;
        w_eff_dirty = w_eff_dirty & ~i_write_way_vec;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hit / victim selection
  // ---------------------------------------------------------------------------
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_inv_found;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_sel_way;
  logic [WAYS-1:0]  w_resp_way_vec;
  logic             w_resp_vdirty;

  assign w_hit     = |w_hit_vec;
  assign w_hit_way = oh_to_idx(w_hit_vec);

  // Scan from the top so the lowest invalid way wins.
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!w_eff_vld[w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  assign w_victim       = w_inv_found ? w_inv_way : plru_victim(w_eff_plru);
  assign w_sel_way      = w_hit ? w_hit_way : w_victim;
  assign w_resp_way_vec = w_hit ? w_hit_vec : ({{(WAYS-1){1'b0}}, 1'b1} << w_victim);
  assign w_resp_vdirty  = ~w_hit & w_eff_vld[w_victim] & w_eff_dirty[w_victim];

  // ---------------------------------------------------------------------------
  // PLRU update: s1 hit first, then fill. The later assignment wins when
  // both target the same set, and it builds on the hit-updated tree.
  // ---------------------------------------------------------------------------
  logic            w_hit_upd;
  logic [WAYS-2:0] w_plru_hit_new;
  logic [WAYS-2:0] w_plru_fill_base;

  assign w_hit_upd        = r_s1_vld & ~i_squash & w_hit;
  assign w_plru_hit_new   = plru_touch(r_plru[r_s1_idx], w_hit_way);
  assign w_plru_fill_base = (w_hit_upd && (w_wr_idx == r_s1_idx)) ? w_plru_hit_new
                                                                  : r_plru[w_wr_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_plru <= '0;
    end else begin
      if (w_hit_upd) begin
        r_plru[r_s1_idx] <= w_plru_hit_new;
      end
      if (w_wr_fill) begin
        r_plru[w_wr_idx] <= plru_touch(w_plru_fill_base, w_wr_way);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // s2 response register
  // ---------------------------------------------------------------------------
  logic              r_resp_vld;
  logic              r_resp_hit;
  logic [WAYS-1:0]   r_resp_way_vec;
  logic [LINE_W-1:0] r_resp_data;
  logic              r_resp_vdirty;
  logic              w_s1_go;

  assign w_s1_go = r_s1_vld & ~i_squash;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_vld     <= 1'b0;
      r_resp_hit     <= 1'b0;
      r_resp_way_vec <= '0;
      r_resp_data    <= '0;
      r_resp_vdirty  <= 1'b0;
    end else begin
      r_resp_vld <= w_s1_go;
      if (w_s1_go) begin
        r_resp_hit     <= w_hit;
        r_resp_way_vec <= w_resp_way_vec;
        r_resp_data    <= w_eff_data[w_sel_way];
        r_resp_vdirty  <= w_resp_vdirty;
      end
    end
  end

  assign o_resp_vld          = r_resp_vld;
  assign o_resp_hit          = r_resp_hit;
  assign o_resp_way_vec      = r_resp_way_vec;
  assign o_resp_data         = r_resp_data;
  assign o_resp_victim_dirty = r_resp_vdirty;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_write_onehot: assert property (@(posedge clk) disable iff (!rst)
    i_write_req |-> $onehot(i_write_way_vec));

  a_single_hit: assert property (@(posedge clk) disable iff (!rst)
    r_s1_vld |-> $onehot0(w_hit_vec));

endmodule

// File: tb/tb_cache_data_array.sv
module tb_cache_data_array;
  localparam int WAYS   = 4;
  localparam int LINE_B = 64;
  localparam int LW     = 8 * LINE_B;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_lookup_req;
  logic          o_lookup_gnt;
  logic [63:0]   i_lookup_addr;
  logic          i_squash;
  logic          o_resp_vld;
  logic          o_resp_hit;
  logic [3:0]    o_resp_way_vec;
  logic [LW-1:0] o_resp_data;
  logic          o_resp_victim_dirty;
  logic          i_write_req;
  logic [1:0]    i_write_op;
  logic [63:0]   i_write_addr;
  logic [3:0]    i_write_way_vec;
  logic [LW-1:0] i_write_data;
  logic [63:0]   i_write_byte_mask;
  logic          i_write_dirty;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_data_array #(.SETS(64), .WAYS(WAYS), .ADDR_WIDTH(64), .LINE_BYTES(LINE_B), .BANKS(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_lookup_req        (i_lookup_req),
    .o_lookup_gnt        (o_lookup_gnt),
    .i_lookup_addr       (i_lookup_addr),
    .i_squash            (i_squash),
    .o_resp_vld          (o_resp_vld),
    .o_resp_hit          (o_resp_hit),
    .o_resp_way_vec      (o_resp_way_vec),
    .o_resp_data         (o_resp_data),
    .o_resp_victim_dirty (o_resp_victim_dirty),
    .i_write_req         (i_write_req),
    .i_write_op          (i_write_op),
    .i_write_addr        (i_write_addr),
    .i_write_way_vec     (i_write_way_vec),
    .i_write_data        (i_write_data),
    .i_write_byte_mask   (i_write_byte_mask),
    .i_write_dirty       (i_write_dirty)
  );

  // offset[5:0], bank[6], index[12:7], tag[63:13]
  function automatic logic [63:0] addr_of(input logic [50:0] tag, input logic [5:0] idx);
    return {tag, idx, 7'h00};
  endfunction

  function automatic logic [LW-1:0] pat(input logic [7:0] seed);
    logic [LW-1:0] p;
    for (int b = 0; b < LINE_B; b++) p[8*b +: 8] = seed + 8'(b * 7);
    return p;
  endfunction

  // Stimulus helpers: enter and leave 1 time unit after a rising edge.
  task automatic wr(input logic [1:0] op, input logic [63:0] addr, input logic [3:0] wv,
                    input logic [LW-1:0] data, input logic [63:0] mask, input logic dirty);
    i_write_req = 1'b1; i_write_op = op; i_write_addr = addr; i_write_way_vec = wv;
    i_write_data = data; i_write_byte_mask = mask; i_write_dirty = dirty;
    @(posedge clk); #1;
    i_write_req = 1'b0;
  endtask

  task automatic lookup_get(input logic [63:0] addr, output logic vld, output logic hit,
                            output logic [3:0] wv, output logic [LW-1:0] data, output logic vd);
    i_lookup_req = 1'b1; i_lookup_addr = addr;
    @(posedge clk); #1;
    i_lookup_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld = o_resp_vld; hit = o_resp_hit; wv = o_resp_way_vec; data = o_resp_data;
    vd = o_resp_victim_dirty;
    @(posedge clk); #1;
  endtask

  logic          c_vld, c_hit, c_vd;
  logic [3:0]    c_wv;
  logic [LW-1:0] c_data;

  task automatic test_reset();
    rst = 1'b1; #2; rst = 1'b0;
    i_lookup_req = 1'b1; i_lookup_addr = 64'h1000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (o_lookup_gnt !== 1'b0) begin n_err++; $display("FAIL reset.gnt got %b want 0", o_lookup_gnt); end
    n_vec++; if (o_resp_vld !== 1'b0) begin n_err++; $display("FAIL reset.vld got %b want 0", o_resp_vld); end
    n_vec++; if (o_resp_hit !== 1'b0) begin n_err++; $display("FAIL reset.hit got %b want 0", o_resp_hit); end
    n_vec++; if (o_resp_way_vec !== 4'b0) begin n_err++; $display("FAIL reset.way_vec got %b want 0000", o_resp_way_vec); end
    n_vec++; if (o_resp_data !== '0) begin n_err++; $display("FAIL reset.data got %h want 0", o_resp_data); end
    n_vec++; if (o_resp_victim_dirty !== 1'b0) begin n_err++; $display("FAIL reset.vdirty got %b want 0", o_resp_victim_dirty); end
    i_lookup_req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    lookup_get(64'h1000, c_vld, c_hit, c_wv, c_data, c_vd);
    n_vec++; if (c_vld !== 1'b1) begin n_err++; $display("FAIL cold.vld got %b want 1", c_vld); end
    n_vec++; if (c_hit !== 1'b0) begin n_err++; $display("FAIL cold.hit got %b want 0", c_hit); end
    n_vec++; if (c_wv !== 4'b0001) begin n_err++; $display("FAIL cold.way_vec got %b want 0001", c_wv); end
    n_vec++; if (c_vd !== 1'b0) begin n_err++; $display("FAIL cold.vdirty got %b want 0", c_vd); end
  endtask

  task automatic test_fill_hit();
    wr(2'd0, 64'h1000, 4'b0100, pat(8'h11), 64'h0, 1'b0);
    lookup_get(64'h1000, c_vld, c_hit, c_wv, c_data, c_vd);
    n_vec++; if (c_vld !== 1'b1) begin n_err++; $display("FAIL fill.vld got %b want 1", c_vld); end
    n_vec++; if (c_hit !== 1'b1) begin n_err++; $display("FAIL fill.hit got %b want 1", c_hit); end
    n_vec++; if (c_wv !== 4'b0100) begin n_err++; $display("FAIL fill.way_vec got %b want 0100", c_wv); end
    n_vec++; if (c_data !== pat(8'h11)) begin n_err++; $display("FAIL fill.data got %h want %h", c_data, pat(8'h11)); end
    n_vec++; if (c_vd !== 1'b0) begin n_err++; $display("FAIL fill.vdirty got %b want 0", c_vd); end
  endtask

  task automatic test_store_inv();
    logic [LW-1:0] sd, exp;
    sd = pat(8'hE0); sd[7:0] = 8'hAA;
    exp = pat(8'h11); exp[7:0] = 8'hAA;
    wr(2'd1, 64'h1000, 4'b0100, sd, 64'h1, 1'b0);
    lookup_get(64'h1000, c_vld, c_hit, c_wv, c_data, c_vd);
    n_vec++; if (c_hit !== 1'b1) begin n_err++; $display("FAIL store.hit got %b want 1", c_hit); end
    n_vec++; if (c_wv !== 4'b0100) begin n_err++; $display("FAIL store.way_vec got %b want 0100", c_wv); end
    n_vec++; if (c_data !== exp) begin n_err++; $display("FAIL store.data got %h want %h", c_data, exp); end
    wr(2'd2, 64'h1000, 4'b0100, '0, 64'h0, 1'b0);
    lookup_get(64'h1000, c_vld, c_hit, c_wv, c_data, c_vd);
    n_vec++; if (c_vld !== 1'b1) begin n_err++; $display("FAIL inv.vld got %b want 1", c_vld); end
    n_vec++; if (c_hit !== 1'b0) begin n_err++; $display("FAIL inv.hit got %b want 0", c_hit); end
    n_vec++; if (c_wv !== 4'b0001) begin n_err++; $display("FAIL inv.way_vec got %b want 0001", c_wv); end
    n_vec++; if (c_vd !== 1'b0) begin n_err++; $display("FAIL inv.vdirty got %b want 0", c_vd); end
  endtask

  task automatic test_arbitration();
    i_lookup_req = 1'b1; i_lookup_addr = 64'h1000; #1;
    n_vec++; if (o_lookup_gnt !== 1'b1) begin n_err++; $display("FAIL arb.gnt_alone got %b want 1", o_lookup_gnt); end
    i_write_req = 1'b1; i_write_op = 2'd3; i_write_way_vec = 4'b0001; i_write_addr = 64'h0; #1;
    n_vec++; if (o_lookup_gnt !== 1'b0) begin n_err++; $display("FAIL arb.gnt_with_write got %b want 0", o_lookup_gnt); end
    @(posedge clk); #1;
    i_lookup_req = 1'b0; i_write_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (o_resp_vld !== 1'b0) begin n_err++; $display("FAIL arb.no_resp got %b want 0", o_resp_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    logic [LW-1:0] sd, exp;
    wr(2'd0, 64'h1000, 4'b0010, pat(8'h40), 64'h0, 1'b0);
    // store lands while the lookup sits in s1
    sd = pat(8'h99); sd[47:40] = 8'h3C;
    exp = pat(8'h40); exp[47:40] = 8'h3C;
    i_lookup_req = 1'b1; i_lookup_addr = 64'h1000;
    @(posedge clk); #1;
    i_lookup_req = 1'b0;
    i_write_req = 1'b1; i_write_op = 2'd1; i_write_addr = 64'h1000; i_write_way_vec = 4'b0010;
    i_write_data = sd; i_write_byte_mask = 64'h20; i_write_dirty = 1'b0;
    @(posedge clk); #1;
    i_write_req = 1'b0;
    @(negedge clk);
    n_vec++; if (o_resp_vld !== 1'b1) begin n_err++; $display("FAIL fwd_store.vld got %b want 1", o_resp_vld); end
    n_vec++; if (o_resp_hit !== 1'b1) begin n_err++; $display("FAIL fwd_store.hit got %b want 1", o_resp_hit); end
    n_vec++; if (o_resp_data !== exp) begin n_err++; $display("FAIL fwd_store.data got %h want %h", o_resp_data, exp); end
    @(posedge clk); #1;
    // fill of the looked-up tag lands in s1
    i_lookup_req = 1'b1; i_lookup_addr = addr_of(51'd1, 6'd32);
    @(posedge clk); #1;
    i_lookup_req = 1'b0;
    i_write_req = 1'b1; i_write_op = 2'd0; i_write_addr = addr_of(51'd1, 6'd32); i_write_way_vec = 4'b1000;
    i_write_data = pat(8'h70); i_write_byte_mask = 64'h0; i_write_dirty = 1'b1;
    @(posedge clk); #1;
    i_write_req = 1'b0;
    @(negedge clk);
    n_vec++; if (o_resp_hit !== 1'b1) begin n_err++; $display("FAIL fwd_fill.hit got %b want 1", o_resp_hit); end
    n_vec++; if (o_resp_way_vec !== 4'b1000) begin n_err++; $display("FAIL fwd_fill.way_vec got %b want 1000", o_resp_way_vec); end
    n_vec++; if (o_resp_data !== pat(8'h70)) begin n_err++; $display("FAIL fwd_fill.data got %h want %h", o_resp_data, pat(8'h70)); end
    @(posedge clk); #1;
    // invalidate of the hit way lands in s1
    i_lookup_req = 1'b1; i_lookup_addr = 64'h1000;
    @(posedge clk); #1;
    i_lookup_req = 1'b0;
    i_write_req = 1'b1; i_write_op = 2'd2; i_write_addr = 64'h1000; i_write_way_vec = 4'b0010;
    @(posedge clk); #1;
    i_write_req = 1'b0;
    @(negedge clk);
    n_vec++; if (o_resp_hit !== 1'b0) begin n_err++; $display("FAIL fwd_inv.hit got %b want 0", o_resp_hit); end
    n_vec++; if (o_resp_way_vec !== 4'b0001) begin n_err++; $display("FAIL fwd_inv.way_vec got %b want 0001", o_resp_way_vec); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 4; w++)
      wr(2'd0, addr_of(51'(w + 1), 6'd5), 4'(1 << w), pat(8'(8'h80 + w)), 64'h0, (w == 1));
    i_lookup_req = 1'b1; i_lookup_addr = addr_of(51'd1, 6'd5);
    @(posedge clk); #1;
    i_lookup_addr = addr_of(51'd3, 6'd5);
    @(posedge clk); #1;
    i_lookup_addr = addr_of(51'd9, 6'd5);
    @(negedge clk);
    n_vec++; if ({o_resp_vld, o_resp_hit, o_resp_way_vec} !== 6'b11_0001) begin n_err++; $display("FAIL b2b.r0 got vld/hit/way %b%b%b want 110001", o_resp_vld, o_resp_hit, o_resp_way_vec); end
    @(posedge clk); #1;
    i_lookup_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({o_resp_vld, o_resp_hit, o_resp_way_vec} !== 6'b11_0100) begin n_err++; $display("FAIL b2b.r1 got vld/hit/way %b%b%b want 110100", o_resp_vld, o_resp_hit, o_resp_way_vec); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if ({o_resp_vld, o_resp_hit, o_resp_way_vec} !== 6'b10_0010) begin n_err++; $display("FAIL plru.victim got vld/hit/way %b%b%b want 100010", o_resp_vld, o_resp_hit, o_resp_way_vec); end
    n_vec++; if (o_resp_victim_dirty !== 1'b1) begin n_err++; $display("FAIL plru.vdirty got %b want 1", o_resp_victim_dirty); end
    n_vec++; if (o_resp_data !== pat(8'h81)) begin n_err++; $display("FAIL plru.data got %h want %h", o_resp_data, pat(8'h81)); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (o_resp_vld !== 1'b0) begin n_err++; $display("FAIL b2b.vld_drop got %b want 0", o_resp_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_squash();
    i_lookup_req = 1'b1; i_lookup_addr = addr_of(51'd2, 6'd5);
    @(posedge clk); #1;
    i_lookup_req = 1'b0; i_squash = 1'b1;
    @(posedge clk); #1;
    i_squash = 1'b0;
    @(negedge clk);
    n_vec++; if (o_resp_vld !== 1'b0) begin n_err++; $display("FAIL squash.vld got %b want 0", o_resp_vld); end
    @(posedge clk); #1;
    lookup_get(addr_of(51'd9, 6'd5), c_vld, c_hit, c_wv, c_data, c_vd);
    n_vec++; if (c_wv !== 4'b0010) begin n_err++; $display("FAIL squash.victim got %b want 0010", c_wv); end
    n_vec++; if (c_vd !== 1'b1) begin n_err++; $display("FAIL squash.vdirty got %b want 1", c_vd); end
    // squash with s1 empty must not touch the lookup being granted
    i_lookup_req = 1'b1; i_lookup_addr = addr_of(51'd4, 6'd5); i_squash = 1'b1;
    @(posedge clk); #1;
    i_lookup_req = 1'b0; i_squash = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if ({o_resp_vld, o_resp_hit, o_resp_way_vec} !== 6'b11_1000) begin n_err++; $display("FAIL squash_empty got vld/hit/way %b%b%b want 111000", o_resp_vld, o_resp_hit, o_resp_way_vec); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    i_lookup_req = 1'b1; i_lookup_addr = addr_of(51'd4, 6'd5);
    @(posedge clk); #1;
    i_lookup_req = 1'b0;
    rst = 1'b0; #1;
    n_vec++; if ({o_resp_vld, o_resp_hit, o_resp_way_vec, o_resp_victim_dirty, o_lookup_gnt} !== 8'h00) begin n_err++; $display("FAIL rst_mid.ctl got %b want 00000000", {o_resp_vld, o_resp_hit, o_resp_way_vec, o_resp_victim_dirty, o_lookup_gnt}); end
    n_vec++; if (o_resp_data !== '0) begin n_err++; $display("FAIL rst_mid.data got %h want 0", o_resp_data); end
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (o_resp_vld !== 1'b0) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid.late_resp got %b want 0", seen); end
    @(posedge clk); #1;
    lookup_get(addr_of(51'd4, 6'd5), c_vld, c_hit, c_wv, c_data, c_vd);
    n_vec++; if ({c_vld, c_hit, c_wv} !== 6'b10_0001) begin n_err++; $display("FAIL rst_mid.after got vld/hit/way %b%b%b want 100001", c_vld, c_hit, c_wv); end
  endtask

  initial begin
    rst = 1'b1;
    i_lookup_req = 1'b0; i_lookup_addr = '0; i_squash = 1'b0;
    i_write_req = 1'b0; i_write_op = '0; i_write_addr = '0; i_write_way_vec = 4'b0001;
    i_write_data = '0; i_write_byte_mask = '0; i_write_dirty = 1'b0;
    test_reset();
    test_fill_hit();
    test_store_inv();
    test_arbitration();
    test_forward();
    test_back_to_back();
    test_squash();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
